// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - CSI-2 data types, CRC constants and packet FSM state type
package csi2_pkg;

    localparam logic [5:0]  DT_FS    = 6'h00;
    localparam logic [5:0]  DT_FE    = 6'h01;
    localparam logic [5:0]  DT_RAW8  = 6'h2A;
    localparam logic [5:0]  DT_RAW10 = 6'h2B;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h8408;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC
    } csi2_state_e;

endpackage

// File: rtl/csi2_ecc_gen.sv
// rtl/csi2_ecc_gen.sv - CSI-2 packet header ECC (6-bit Hamming over DI and WC)
module csi2_ecc_gen (
    input  logic [23:0] data,
    output logic [7:0]  ecc
);

    // Each mask selects the header bits that feed one parity bit.
    localparam logic [23:0] P0_MASK = 24'hF12CB7;
    localparam logic [23:0] P1_MASK = 24'hF2555B;
    localparam logic [23:0] P2_MASK = 24'h749A6D;
    localparam logic [23:0] P3_MASK = 24'hB8E38E;
    localparam logic [23:0] P4_MASK = 24'hDF03F0;
    localparam logic [23:0] P5_MASK = 24'hEFFC00;

    assign ecc = {2'b00,
                  ^(data & P5_MASK),
                  ^(data & P4_MASK),
                  ^(data & P3_MASK),
                  ^(data & P2_MASK),
                  ^(data & P1_MASK),
                  ^(data & P0_MASK)};

endmodule

// File: rtl/pixel_to_byte.sv
// rtl/pixel_to_byte.sv - packs RAW8/RAW10 pixels into CSI-2 short and long packet byte streams
module pixel_to_byte
    import csi2_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  vc,
    input  logic [15:0] wc,
    input  logic        dt_raw10,
    input  logic        fs_req,
    input  logic        fe_req,
    input  logic        line_req,
    input  logic [9:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        sop,
    output logic        eop,
    output logic        busy,
    output logic        frame_active,
    output logic        req_err
);

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    csi2_state_e state_q, state_d;
    logic [2:0]  sub_cnt_q, sub_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [2:0]  grp_q, grp_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [15:0] crc_q, crc_d;
    logic [1:0]  vc_q, vc_d;
    logic [15:0] wc_q, wc_d;
    logic        raw10_q, raw10_d;
    logic [5:0]  dt_q, dt_d;
    logic        long_q, long_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        frame_q, frame_d;
    logic        req_err_q, req_err_d;

    logic        load_ok, xfer, any_req;
    logic        line_bad, take_short, take_line;
    logic [5:0]  new_dt;
    logic        lsb_turn;
    logic [7:0]  pay_byte;
    logic [7:0]  ecc;
    logic        pix_ready_c;

    csi2_ecc_gen u_ecc (
        .data ({wc_q, vc_q, dt_q}),
        .ecc  (ecc)
    );

    // The output register refills whenever it is empty or being drained this cycle.
    assign load_ok    = !valid_q || byte_ready;
    assign xfer       = valid_q && byte_ready;
    assign any_req    = fs_req || fe_req || line_req;
    assign line_bad   = (wc == 16'd0) || (dt_raw10 && ((wc % 16'd5) != 16'd0));
    assign take_short = fs_req || (fe_req && !line_req);
    assign take_line  = !fs_req && line_req && !line_bad;
    assign new_dt     = fs_req   ? DT_FS :
                        line_req ? (dt_raw10 ? DT_RAW10 : DT_RAW8) : DT_FE;
    assign lsb_turn   = raw10_q && (grp_q == 3'd4);
    assign pay_byte   = lsb_turn ? lsb_q : (raw10_q ? pix_in[9:2] : pix_in[7:0]);

    always_comb begin
        state_d     = state_q;
        sub_cnt_d   = sub_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        grp_d       = grp_q;
        lsb_d       = lsb_q;
        crc_d       = crc_q;
        vc_d        = vc_q;
        wc_d        = wc_q;
        raw10_d     = raw10_q;
        dt_d        = dt_q;
        long_d      = long_q;
        byte_d      = byte_q;
        valid_d     = valid_q && !byte_ready;
        sop_d       = sop_q;
        eop_d       = eop_q;
        frame_d     = frame_q;
        req_err_d   = 1'b0;
        pix_ready_c = 1'b0;

        if (state_q != ST_IDLE && any_req) req_err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (take_short || take_line) begin
                    vc_d      = vc;
                    dt_d      = new_dt;
                    long_d    = take_line;
                    raw10_d   = take_line && dt_raw10;
                    wc_d      = take_line ? wc : 16'd0;
                    crc_d     = CRC_INIT;
                    byte_d    = {vc, new_dt};
                    valid_d   = 1'b1;
                    sop_d     = 1'b1;
                    eop_d     = 1'b0;
                    sub_cnt_d = 3'd1;
                    state_d   = ST_HDR;
                end else if (line_req && !fs_req) begin
                    req_err_d = 1'b1;
                end
            end

            ST_HDR: begin
                if (sub_cnt_q == 3'd4) begin
                    // Short packet: stay busy until the ECC byte has actually left.
                    if (xfer) begin
                        state_d = ST_IDLE;
                        if (dt_q == DT_FS)      frame_d = 1'b1;
                        else if (dt_q == DT_FE) frame_d = 1'b0;
                    end
                end else if (load_ok) begin
                    valid_d   = 1'b1;
                    sop_d     = 1'b0;
                    eop_d     = 1'b0;
                    sub_cnt_d = sub_cnt_q + 3'd1;
                    case (sub_cnt_q[1:0])
                        2'd1:    byte_d = wc_q[7:0];
                        2'd2:    byte_d = wc_q[15:8];
                        default: begin
                            byte_d = ecc;
                            eop_d  = !long_q;
                            if (long_q) begin
                                state_d   = ST_PAYLOAD;
                                pay_cnt_d = 16'd0;
                                grp_d     = 3'd0;
                            end
                        end
                    endcase
                end
            end

            ST_PAYLOAD: begin
                pix_ready_c = load_ok && !lsb_turn;
                if (load_ok && (lsb_turn || pix_valid)) begin
                    if (raw10_q && !lsb_turn) lsb_d[{grp_q[1:0], 1'b0} +: 2] = pix_in[1:0];
                    grp_d     = (raw10_q && !lsb_turn) ? grp_q + 3'd1 : 3'd0;
                    byte_d    = pay_byte;
                    valid_d   = 1'b1;
                    sop_d     = 1'b0;
                    eop_d     = 1'b0;
                    crc_d     = crc16_byte(crc_q, pay_byte);
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    if (pay_cnt_q == wc_q - 16'd1) begin
                        state_d   = ST_CRC;
                        sub_cnt_d = 3'd0;
                    end
                end
            end

            ST_CRC: begin
                if (sub_cnt_q == 3'd2) begin
                    if (xfer) state_d = ST_IDLE;
                end else if (load_ok) begin
                    valid_d   = 1'b1;
                    sop_d     = 1'b0;
                    byte_d    = sub_cnt_q[0] ? crc_q[15:8] : crc_q[7:0];
                    eop_d     = sub_cnt_q[0];
                    sub_cnt_d = sub_cnt_q + 3'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sub_cnt_q <= 3'd0;
            pay_cnt_q <= 16'd0;
            grp_q     <= 3'd0;
            lsb_q     <= 8'd0;
            crc_q     <= CRC_INIT;
            vc_q      <= 2'd0;
            wc_q      <= 16'd0;
            raw10_q   <= 1'b0;
            dt_q      <= 6'd0;
            long_q    <= 1'b0;
            byte_q    <= 8'd0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            frame_q   <= 1'b0;
            req_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sub_cnt_q <= sub_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            grp_q     <= grp_d;
            lsb_q     <= lsb_d;
            crc_q     <= crc_d;
            vc_q      <= vc_d;
            wc_q      <= wc_d;
            raw10_q   <= raw10_d;
            dt_q      <= dt_d;
            long_q    <= long_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            frame_q   <= frame_d;
            req_err_q <= req_err_d;
        end
    end

    assign pix_ready    = pix_ready_c;
    assign byte_out     = byte_q;
    assign byte_valid   = valid_q;
    assign sop          = sop_q;
    assign eop          = eop_q;
    assign busy         = (state_q != ST_IDLE);
    assign frame_active = frame_q;
    assign req_err      = req_err_q;

endmodule

// File: tb/tb_pixel_to_byte.sv
// tb/tb_pixel_to_byte.sv - scoreboard bench for pixel_to_byte
module tb_pixel_to_byte;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  vc;
    logic [15:0] wc;
    logic        dt_raw10;
    logic        fs_req, fe_req, line_req;
    logic [9:0]  pix_in;
    logic        pix_valid, pix_ready;
    logic [7:0]  byte_out;
    logic        byte_valid, byte_ready;
    logic        sop, eop, busy, frame_active, req_err;

    always #5 clk = ~clk;

    pixel_to_byte dut (
        .clk(clk), .reset(reset), .vc(vc), .wc(wc), .dt_raw10(dt_raw10),
        .fs_req(fs_req), .fe_req(fe_req), .line_req(line_req),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .sop(sop), .eop(eop), .busy(busy), .frame_active(frame_active), .req_err(req_err)
    );

    int         checks = 0;
    int         failures = 0;
    logic [9:0] exp_q[$];
    logic [9:0] pix_q[$];
    logic [7:0] pay_q[$];
    int         xfer_count = 0;
    int         pix_taken = 0;
    bit         rand_ready = 1'b0;
    logic [7:0] crc_vec [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction

    task automatic push_b(input logic [7:0] b, input logic s, input logic e);
        exp_q.push_back({s, e, b});
    endtask

    task automatic push_hdr(input logic [7:0] di, input logic [15:0] w, input logic [7:0] ecc, input logic is_short);
        push_b(di, 1'b1, 1'b0);
        push_b(w[7:0], 1'b0, 1'b0);
        push_b(w[15:8], 1'b0, 1'b0);
        push_b(ecc, 1'b0, is_short);
    endtask

    task automatic push_pay(output logic [15:0] crc);
        crc = 16'hFFFF;
        foreach (pay_q[i]) begin
            push_b(pay_q[i], 1'b0, 1'b0);
            crc = crc_step(crc, pay_q[i]);
        end
        pay_q.delete();
    endtask

    task automatic push_crc(input logic [15:0] crc);
        push_b(crc[7:0], 1'b0, 1'b0);
        push_b(crc[15:8], 1'b0, 1'b1);
    endtask

    // kind: bit0 fs_req, bit1 fe_req, bit2 line_req
    task automatic request(input logic [2:0] kind, input logic [1:0] v, input logic [15:0] w, input logic r10);
        @(negedge clk);
        vc = v; wc = w; dt_raw10 = r10;
        fs_req = kind[0]; fe_req = kind[1]; line_req = kind[2];
        @(negedge clk);
        fs_req = 1'b0; fe_req = 1'b0; line_req = 1'b0;
        vc = ~v; wc = 16'hBEEF; dt_raw10 = ~r10;
    endtask

    task automatic err_window(input string name, input int expected);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (req_err) cnt++;
            @(negedge clk);
        end
        check(name, 32'(cnt), 32'(expected));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk); #3;
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 500);
        if (exp_q.size() != 0 || busy) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%0d_pending required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Input driver: byte_ready and pixel source change on the falling edge.
    initial begin
        byte_ready = 1'b1; pix_valid = 1'b0; pix_in = 10'd0;
        forever begin
            @(negedge clk);
            byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_q.size() > 0) begin
                pix_valid = 1'b1; pix_in = pix_q[0];
            end else begin
                pix_valid = 1'b0; pix_in = 10'd0;
            end
            #1;
            if (!reset && pix_valid && pix_ready) begin
                void'(pix_q.pop_front());
                pix_taken++;
            end
        end
    end

    // Monitor: predicts the transfer at the coming rising edge and scores it.
    initial begin
        logic       prev_stall;
        logic [9:0] prev_out;
        logic [9:0] e;
        prev_stall = 1'b0; prev_out = 10'd0;
        forever begin
            @(negedge clk); #2;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("stall_hold", 32'({byte_valid, sop, eop, byte_out}), 32'({1'b1, prev_out}));
                if (!rand_ready && busy) check("no_bubble", 32'(byte_valid), 32'd1);
                if (byte_valid && byte_ready) begin
                    xfer_count++;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_byte actual=0x%0h required=none", byte_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_sop_eop", 32'({sop, eop, byte_out}), 32'(e));
                    end
                end
                prev_stall = byte_valid && !byte_ready;
                prev_out   = {sop, eop, byte_out};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] crc;
        int          base, n;
        crc_vec = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                    8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                    8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        reset = 1'b1; vc = 2'd0; wc = 16'd0; dt_raw10 = 1'b0;
        fs_req = 1'b0; fe_req = 1'b0; line_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_active", 32'(frame_active), 32'd0);
        check("rst_req_err", 32'(req_err), 32'd0);
        check("rst_sop_eop", 32'({sop, eop}), 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Frame start on VC1
        push_hdr(8'h40, 16'h0000, 8'h16, 1'b1);
        request(3'b001, 2'd1, 16'd0, 1'b0);
        err_window("fs_no_err", 0);
        wait_done("fs_vc1");
        check("fs_frame_active", 32'(frame_active), 32'd1);

        // RAW8 line, wc=4
        pix_q = '{10'h011, 10'h022, 10'h033, 10'h044};
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_hdr(8'h2A, 16'd4, 8'h33, 1'b0);
        push_pay(crc); push_crc(crc);
        request(3'b100, 2'd0, 16'd4, 1'b0);
        wait_done("raw8_wc4");

        // RAW10 line, wc=5, with one spare pixel that must not be consumed
        pix_taken = 0;
        pix_q = '{10'h3FF, 10'h001, 10'h2AA, 10'h155, 10'h0AB};
        pay_q = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'h67};
        push_hdr(8'h2B, 16'd5, 8'h2E, 1'b0);
        push_pay(crc); push_crc(crc);
        request(3'b100, 2'd0, 16'd5, 1'b1);
        wait_done("raw10_wc5");
        check("raw10_pix_consumed", 32'(pix_taken), 32'd4);
        check("raw10_pix_left", 32'(pix_q.size()), 32'd1);
        pix_q.delete();

        // RAW10 line, wc=10: stall-free pass then random byte_ready pass
        for (int pass = 0; pass < 2; pass++) begin
            rand_ready = (pass == 1);
            pix_q = '{10'h123, 10'h3C5, 10'h07E, 10'h2B9, 10'h001, 10'h3FE, 10'h200, 10'h155};
            pay_q = '{8'h48, 8'hF1, 8'h1F, 8'hAE, 8'h67, 8'h00, 8'hFF, 8'h80, 8'h55, 8'h49};
            push_hdr(8'h2B, 16'd10, 8'h2E, 1'b0);
            push_pay(crc); push_crc(crc);
            request(3'b100, 2'd0, 16'd10, 1'b1);
            wait_done(pass == 0 ? "raw10_wc10" : "raw10_wc10_stall");
        end
        rand_ready = 1'b0;

        // RAW8 line carrying the published 24-byte CRC example (CRC 0x00F0)
        for (int i = 0; i < 24; i++) begin
            pix_q.push_back({2'b00, crc_vec[i]});
        end
        push_hdr(8'h2A, 16'd24, 8'h13, 1'b0);
        for (int i = 0; i < 24; i++) push_b(crc_vec[i], 1'b0, 1'b0);
        push_crc(16'h00F0);
        request(3'b100, 2'd0, 16'd24, 1'b0);
        wait_done("crc_example");

        // Rejected line requests
        request(3'b100, 2'd0, 16'd6, 1'b1);
        err_window("raw10_wc6_err", 1);
        check("raw10_wc6_idle", 32'(busy), 32'd0);
        request(3'b100, 2'd0, 16'd0, 1'b0);
        err_window("wc0_err", 1);
        check("wc0_idle", 32'(busy), 32'd0);

        // FS request while a line is in flight
        pix_q = '{10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD};
        pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        push_hdr(8'h2A, 16'd4, 8'h33, 1'b0);
        push_pay(crc); push_crc(crc);
        request(3'b100, 2'd0, 16'd4, 1'b0);
        request(3'b001, 2'd2, 16'd0, 1'b0);
        err_window("midpkt_fs_err", 1);
        wait_done("midpkt_line");

        // FS and FE together: only FS goes out
        push_hdr(8'h00, 16'h0000, 8'h00, 1'b1);
        request(3'b011, 2'd0, 16'd0, 1'b0);
        err_window("fs_fe_no_err", 0);
        wait_done("fs_fe_same");
        check("fs_fe_frame_active", 32'(frame_active), 32'd1);

        push_hdr(8'h01, 16'h0000, 8'h07, 1'b1);
        request(3'b010, 2'd0, 16'd0, 1'b0);
        wait_done("fe_vc0");
        check("fe_frame_active", 32'(frame_active), 32'd0);

        // Reset after the second payload byte, then a fresh FE
        push_hdr(8'h00, 16'h0000, 8'h00, 1'b1);
        request(3'b001, 2'd0, 16'd0, 1'b0);
        wait_done("fs_before_reset");
        pix_q = '{10'h101, 10'h102, 10'h103, 10'h104};
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_hdr(8'h2A, 16'd4, 8'h33, 1'b0);
        push_pay(crc); push_crc(crc);
        base = xfer_count;
        request(3'b100, 2'd0, 16'd4, 1'b0);
        n = 0;
        while (xfer_count < base + 6 && n < 200) begin
            @(negedge clk); #3;
            n++;
        end
        if (xfer_count < base + 6) begin
            checks++; failures++;
            $display("FAIL reset_wait_timeout actual=%0d required=%0d", xfer_count - base, 6);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        check("midrst_byte_valid", 32'(byte_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frame_active", 32'(frame_active), 32'd0);
        exp_q.delete();
        pix_q.delete();
        @(negedge clk);
        reset = 1'b0;
        push_hdr(8'h01, 16'h0000, 8'h07, 1'b1);
        request(3'b010, 2'd0, 16'd0, 1'b0);
        err_window("post_rst_no_err", 0);
        wait_done("fe_after_reset");
        check("post_rst_frame_active", 32'(frame_active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
